pipe_link_pwr_seq: RTL and testbench

PIPE-side link power and receiver-detect sequencer for one port of the back-to-back PHY bench (instantiated once per upstream/downstream port). It brings a PHY out of reset in P1, runs receiver detection with retries, moves the PHY to P0 and releases transmitter electrical idle. It also tears the link down on request or on prolonged receive electrical idle. All PIPE power-state changes are handshaked on PhyStatus and guarded by a timeout.

---
 rtl/pipe_link_pwr_seq.sv | 135 +++++++++++++
 tb/tb_pipe_link_pwr_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_link_pwr_seq.sv
// PIPE link power / receiver-detect sequencer for one port.
// Brings the PHY out of reset, detects the receiver with retries, enters P0 and tears the link down on request or on idle loss.
module pipe_link_pwr_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned QUIET_CYCLES   = 64,
    parameter int unsigned MAX_RETRIES    = 4,
    parameter int unsigned IDLE_CYCLES    = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               link_en,
    input  logic                               phy_status,
    input  logic [2:0]                         rx_status,
    input  logic                               rx_elec_idle,
    output logic [1:0]                         power_down,
    output logic                               tx_detect_rx,
    output logic                               tx_elec_idle,
    output logic                               link_up,
    output logic                               detect_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [2:0]                         seq_state
);

    localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);
    localparam int unsigned MAX_A   = (TIMEOUT_CYCLES > QUIET_CYCLES) ? TIMEOUT_CYCLES : QUIET_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > IDLE_CYCLES) ? MAX_A : IDLE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] PD_P0 = 2'b00;
    localparam logic [1:0] PD_P1 = 2'b10;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_P1     = 3'd1,
        S_DETECT = 3'd2,
        S_QUIET  = 3'd3,
        S_P0REQ  = 3'd4,
        S_ACTIVE = 3'd5,
        S_P1EXIT = 3'd6,
        S_FAIL   = 3'd7
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;

    state_t          w_nxt;
    logic            w_retry_inc;
    logic [RW-1:0]   w_retry_new;
    logic            w_hs_to;
    logic            w_quiet_done;
    logic            w_idle_loss;
    logic [CW-1:0]   w_cnt_nxt;

    assign w_retry_new  = retry_cnt + RW'(1);
    assign w_hs_to      = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_quiet_done = (r_cnt == CW'(QUIET_CYCLES - 1));
    assign w_idle_loss  = rx_elec_idle && (r_cnt == CW'(IDLE_CYCLES - 1));

    // phy_status is tested before the timeout so a coincident pulse wins
    always_comb begin
        w_nxt       = r_state;
        w_retry_inc = 1'b0;
        unique case (r_state)
            S_RESET:  if (!phy_status) w_nxt = S_P1;
            S_P1:     if (link_en) w_nxt = S_DETECT;
            S_DETECT: begin
                if (phy_status) begin
                    if (!link_en) begin
                        w_nxt = S_P1;
                    end else if (rx_status == 3'b011) begin
                        w_nxt = S_P0REQ;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_nxt = (w_retry_new == RW'(MAX_RETRIES)) ? S_FAIL : S_QUIET;
                    end
                end else if (w_hs_to) begin
                    w_nxt = S_FAIL;
                end
            end
            S_QUIET: begin
                if (!link_en)          w_nxt = S_P1;
                else if (w_quiet_done) w_nxt = S_DETECT;
            end
            S_P0REQ: begin
                if (phy_status)   w_nxt = link_en ? S_ACTIVE : S_P1EXIT;
                else if (w_hs_to) w_nxt = S_FAIL;
            end
            S_ACTIVE: if (!link_en || w_idle_loss) w_nxt = S_P1EXIT;
            S_P1EXIT: begin
                if (phy_status)   w_nxt = S_P1;
                else if (w_hs_to) w_nxt = S_FAIL;
            end
            S_FAIL:   if (!link_en) w_nxt = S_P1;
            default:  w_nxt = S_RESET;
        endcase
    end

    // One counter serves timeout, quiet gap and idle run; it restarts on every state change
    always_comb begin
        w_cnt_nxt = '0;
        if (w_nxt == r_state) begin
            unique case (r_state)
                S_DETECT, S_QUIET, S_P0REQ, S_P1EXIT: w_cnt_nxt = r_cnt + CW'(1);
                S_ACTIVE: w_cnt_nxt = rx_elec_idle ? r_cnt + CW'(1) : '0;
                default:  w_cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RESET;
            r_cnt        <= '0;
            power_down   <= PD_P1;
            tx_detect_rx <= 1'b0;
            tx_elec_idle <= 1'b1;
            link_up      <= 1'b0;
            detect_fail  <= 1'b0;
            retry_cnt    <= '0;
            seq_state    <= 3'd0;
        end else begin
            r_state      <= w_nxt;
            r_cnt        <= w_cnt_nxt;
            power_down   <= (w_nxt == S_P0REQ || w_nxt == S_ACTIVE) ? PD_P0 : PD_P1;
            tx_detect_rx <= (w_nxt == S_DETECT);
            tx_elec_idle <= (w_nxt != S_ACTIVE);
            link_up      <= (w_nxt == S_ACTIVE);
            detect_fail  <= (w_nxt == S_FAIL);
            seq_state    <= w_nxt;
            if (w_nxt == S_P1 || w_nxt == S_RESET) retry_cnt <= '0;
            else if (w_retry_inc)                  retry_cnt <= w_retry_new;
        end
    end

endmodule

// File: tb/tb_pipe_link_pwr_seq.sv
// Directed bench for pipe_link_pwr_seq: bring-up, retries, timeout, idle loss and reset.
module tb_pipe_link_pwr_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_en;
    logic       phy_status;
    logic [2:0] rx_status;
    logic       rx_elec_idle;
    logic [1:0] power_down;
    logic       tx_detect_rx;
    logic       tx_elec_idle;
    logic       link_up;
    logic       detect_fail;
    logic [2:0] retry_cnt;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_err    = 0;

    pipe_link_pwr_seq #(
        .TIMEOUT_CYCLES(1024),
        .QUIET_CYCLES  (64),
        .MAX_RETRIES   (4),
        .IDLE_CYCLES   (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .link_en     (link_en),
        .phy_status  (phy_status),
        .rx_status   (rx_status),
        .rx_elec_idle(rx_elec_idle),
        .power_down  (power_down),
        .tx_detect_rx(tx_detect_rx),
        .tx_elec_idle(tx_elec_idle),
        .link_up     (link_up),
        .detect_fail (detect_fail),
        .retry_cnt   (retry_cnt),
        .seq_state   (seq_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int exp);
        chk(tag, int'(seq_state), exp);
    endtask

    // single-cycle phy_status pulse carrying the given rx_status
    task automatic pulse(input logic [2:0] rs);
        phy_status = 1'b1;
        rx_status  = rs;
        tick();
        phy_status = 1'b0;
        rx_status  = 3'b000;
    endtask

    task automatic quiet_gap(input string tag);
        tick(63);
        chk_st({tag, "_quiet_hold"}, 3);
        tick();
        chk_st({tag, "_quiet_done"}, 2);
    endtask

    initial begin
        rst = 1'b1; link_en = 1'b0; phy_status = 1'b1; rx_status = 3'b000; rx_elec_idle = 1'b0;
        tick(2);
        chk_st("rst_state", 0);
        chk("rst_pd", int'(power_down), 2);
        chk("rst_txei", int'(tx_elec_idle), 1);
        chk("rst_det", int'(tx_detect_rx), 0);
        chk("rst_up", int'(link_up), 0);
        chk("rst_fail", int'(detect_fail), 0);
        chk("rst_retry", int'(retry_cnt), 0);

        // bring-up: RESET holds while phy_status high even with link_en
        rst = 1'b0; link_en = 1'b1;
        tick(10);
        chk_st("reset_hold", 0);
        phy_status = 1'b0;
        tick();
        chk_st("to_p1", 1);
        tick();
        chk_st("to_detect", 2);
        chk("detect_txdet", int'(tx_detect_rx), 1);
        tick(2);
        pulse(3'b011);
        chk_st("to_p0req", 4);
        chk("p0req_pd", int'(power_down), 0);
        chk("p0req_txdet", int'(tx_detect_rx), 0);
        chk("p0req_txei", int'(tx_elec_idle), 1);
        tick(4);
        chk_st("p0req_wait", 4);
        pulse(3'b000);
        chk_st("to_active", 5);
        chk("active_txei", int'(tx_elec_idle), 0);
        chk("active_up", int'(link_up), 1);
        chk("active_retry", int'(retry_cnt), 0);

        // link loss: 255 idle samples survive, 256 do not
        rx_elec_idle = 1'b1;
        tick(255);
        rx_elec_idle = 1'b0;
        chk_st("idle255", 5);
        tick();
        chk_st("idle_break", 5);
        rx_elec_idle = 1'b1;
        tick(255);
        chk_st("idle255b", 5);
        tick();
        chk_st("idle256", 6);
        chk("p1exit_txei", int'(tx_elec_idle), 1);
        chk("p1exit_pd", int'(power_down), 2);
        chk("p1exit_up", int'(link_up), 0);
        rx_elec_idle = 1'b0;
        pulse(3'b000);
        chk_st("p1exit_to_p1", 1);
        tick();
        chk_st("redetect", 2);

        // retry to failure
        for (int k = 1; k <= 3; k++) begin
            pulse(3'b000);
            chk_st("fail_quiet", 3);
            chk("fail_retry", int'(retry_cnt), k);
            chk("quiet_txdet", int'(tx_detect_rx), 0);
            quiet_gap("rf");
        end
        pulse(3'b000);
        chk_st("to_fail", 7);
        chk("fail_flag", int'(detect_fail), 1);
        chk("fail_retry4", int'(retry_cnt), 4);
        chk("fail_pd", int'(power_down), 2);
        tick(3);
        chk_st("fail_hold", 7);
        link_en = 1'b0;
        tick();
        chk_st("fail_to_p1", 1);
        chk("p1_retry_clr", int'(retry_cnt), 0);
        chk("p1_fail_clr", int'(detect_fail), 0);

        // retry then success
        link_en = 1'b1;
        tick();
        chk_st("rs_detect", 2);
        for (int k = 0; k < 2; k++) begin
            pulse(3'b001);
            chk_st("rs_quiet", 3);
            quiet_gap("rs");
        end
        pulse(3'b011);
        chk_st("rs_p0req", 4);
        pulse(3'b000);
        chk_st("rs_active", 5);
        chk("rs_retry2", int'(retry_cnt), 2);

        // P0REQ timeout
        link_en = 1'b0;
        tick();
        chk_st("drop_p1exit", 6);
        pulse(3'b000);
        chk_st("drop_p1", 1);
        link_en = 1'b1;
        tick();
        pulse(3'b011);
        chk_st("to_p0req2", 4);
        tick(1023);
        chk_st("to_1023", 4);
        tick();
        chk_st("to_1024", 7);
        chk("to_retry", int'(retry_cnt), 0);
        link_en = 1'b0;
        tick();
        link_en = 1'b1;
        tick();
        pulse(3'b011);
        chk_st("to_p0req3", 4);
        tick(1023);
        pulse(3'b000);
        chk_st("collide_active", 5);

        // reset in P0REQ
        link_en = 1'b0;
        tick();
        pulse(3'b000);
        link_en = 1'b1;
        tick();
        pulse(3'b011);
        chk_st("pre_rst_p0req", 4);
        rst = 1'b1;
        tick();
        chk_st("mid_rst_state", 0);
        chk("mid_rst_pd", int'(power_down), 2);
        chk("mid_rst_txei", int'(tx_elec_idle), 1);
        chk("mid_rst_up", int'(link_up), 0);
        chk("mid_rst_det", int'(tx_detect_rx), 0);

        // link_en falling in DETECT: pulse completes, then P1
        rst = 1'b0;
        tick();
        chk_st("post_rst_p1", 1);
        tick();
        chk_st("late_detect", 2);
        link_en = 1'b0;
        tick();
        chk_st("drop_in_detect", 2);
        pulse(3'b011);
        chk_st("detect_drop_p1", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
